// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM stage: one load/store per instruction over a valid/ready bus, registered writeback.
// Optional MEM_MISALIGN_TRAP_EN: misaligned accesses skip the bus and report misalign_err instead.
module mem_access_stage #(
    parameter int XLEN        = 32,
    parameter int RFIDX_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic                   wb_reg_write,
    input  logic                   wb_memtoreg,
    input  logic [XLEN-1:0]        ex_result,
    input  logic [XLEN-1:0]        rs2_data,
    input  logic [2:0]             mem_mode,
    input  logic [RFIDX_WIDTH-1:0] rd_index,
    output logic                   stall,
    output logic                   bus_req_valid,
    input  logic                   bus_req_ready,
    output logic                   bus_req_we,
    output logic [XLEN-1:0]        bus_req_addr,
    output logic [XLEN-1:0]        bus_req_wdata,
    output logic [3:0]             bus_req_wstrb,
    input  logic                   bus_rsp_valid,
    input  logic [XLEN-1:0]        bus_rsp_rdata,
    output logic                   wb_valid,
    output logic                   wb_reg_write_out,
    output logic                   wb_memtoreg_out,
    output logic [XLEN-1:0]        wb_alu_result,
    output logic [XLEN-1:0]        wb_load_data,
    output logic [RFIDX_WIDTH-1:0] wb_rd_index
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic                   misalign_err
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state;
    logic [2:0]  mode_q;
    logic [1:0]  off_q;
    logic [1:0]  off;
    logic        mem_op;
    logic        misaligned;
    logic [XLEN-1:0] st_wdata;
    logic [3:0]      st_wstrb;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_fmt;

    assign off    = ex_result[1:0];
    assign mem_op = mem_read | mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
    assign misaligned = ((mem_mode[1:0] == 2'b01) && off[0]) || (mem_mode[1] && (off != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign stall = ((state == IDLE) && in_valid && mem_op && !misaligned)
                 || (state == REQ) || (state == WAIT);

    // Store lanes are replicated so the bus only needs the strobes to pick the byte(s).
    always_comb begin
        st_wdata = rs2_data;
        st_wstrb = 4'b1111;
        case (mem_mode[1:0])
            2'b00: begin
                st_wdata = {4{rs2_data[7:0]}};
                st_wstrb = 4'b0001 << off;
            end
            2'b01: begin
                st_wdata = {2{rs2_data[15:0]}};
                st_wstrb = off[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte = bus_rsp_rdata[{off_q, 3'b000} +: 8];
        ld_half = off_q[1] ? bus_rsp_rdata[31:16] : bus_rsp_rdata[15:0];
        case (mode_q)
            3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_fmt = {24'h0, ld_byte};
            3'b101:  ld_fmt = {16'h0, ld_half};
            default: ld_fmt = bus_rsp_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            mode_q           <= 3'b000;
            off_q            <= 2'b00;
            bus_req_valid    <= 1'b0;
            bus_req_we       <= 1'b0;
            bus_req_addr     <= '0;
            bus_req_wdata    <= '0;
            bus_req_wstrb    <= 4'b0000;
            wb_valid         <= 1'b0;
            wb_reg_write_out <= 1'b0;
            wb_memtoreg_out  <= 1'b0;
            wb_alu_result    <= '0;
            wb_load_data     <= '0;
            wb_rd_index      <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_err     <= 1'b0;
`endif
        end else begin
            wb_valid <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        wb_reg_write_out <= wb_reg_write & in_valid;
                        wb_memtoreg_out  <= wb_memtoreg;
                        wb_alu_result    <= ex_result;
                        wb_load_data     <= '0;
                        wb_rd_index      <= rd_index;
`ifdef MEM_MISALIGN_TRAP_EN
                        if (mem_op && misaligned) begin
                            wb_valid         <= 1'b1;
                            wb_reg_write_out <= 1'b0;
                            misalign_err     <= 1'b1;
                        end else
`endif
                        if (mem_op) begin
                            // A set mem_read wins over mem_write: the op is a load.
                            state         <= REQ;
                            bus_req_valid <= 1'b1;
                            bus_req_we    <= ~mem_read;
                            bus_req_addr  <= {ex_result[XLEN-1:2], 2'b00};
                            bus_req_wdata <= mem_read ? '0 : st_wdata;
                            bus_req_wstrb <= mem_read ? 4'b0000 : st_wstrb;
                            mode_q        <= mem_mode;
                            off_q         <= off;
                        end else begin
                            wb_valid <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (bus_req_ready) begin
                        bus_req_valid <= 1'b0;
                        if (bus_req_we) begin
                            state    <= DONE;
                            wb_valid <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (bus_rsp_valid) begin
                        wb_load_data <= ld_fmt;
                        wb_valid     <= 1'b1;
                        state        <= DONE;
                    end
                end
                default: begin
                    // DONE: upstream advances on this edge, so the held slot is not re-issued.
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - scoreboard bench for mem_access_stage.
module tb_mem_access_stage;

    typedef struct packed {
        logic        rw;
        logic        mt;
        logic [31:0] alu;
        logic [31:0] ld;
        logic [4:0]  rd;
    } wb_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [2:0]  mode;
        int          rdy;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } st_vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  mode;
        int          rsp_dly;
        logic [31:0] rdata;
        logic [31:0] ld;
    } ld_vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic        wb_reg_write = 1'b0;
    logic        wb_memtoreg = 1'b0;
    logic [31:0] ex_result = '0;
    logic [31:0] rs2_data = '0;
    logic [2:0]  mem_mode = '0;
    logic [4:0]  rd_index = '0;
    logic        stall;
    logic        bus_req_valid;
    logic        bus_req_ready = 1'b0;
    logic        bus_req_we;
    logic [31:0] bus_req_addr;
    logic [31:0] bus_req_wdata;
    logic [3:0]  bus_req_wstrb;
    logic        bus_rsp_valid = 1'b0;
    logic [31:0] bus_rsp_rdata = '0;
    logic        wb_valid;
    logic        wb_reg_write_out;
    logic        wb_memtoreg_out;
    logic [31:0] wb_alu_result;
    logic [31:0] wb_load_data;
    logic [4:0]  wb_rd_index;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_err;
`endif

    int  pass_cnt = 0;
    int  total_cnt = 0;
    wb_t sb[$];

    mem_access_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mem_read(mem_read),
        .mem_write(mem_write), .wb_reg_write(wb_reg_write), .wb_memtoreg(wb_memtoreg),
        .ex_result(ex_result), .rs2_data(rs2_data), .mem_mode(mem_mode), .rd_index(rd_index),
        .stall(stall), .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_req_we(bus_req_we), .bus_req_addr(bus_req_addr), .bus_req_wdata(bus_req_wdata),
        .bus_req_wstrb(bus_req_wstrb), .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata),
        .wb_valid(wb_valid), .wb_reg_write_out(wb_reg_write_out), .wb_memtoreg_out(wb_memtoreg_out),
        .wb_alu_result(wb_alu_result), .wb_load_data(wb_load_data), .wb_rd_index(wb_rd_index)
`ifdef MEM_MISALIGN_TRAP_EN
        , .misalign_err(misalign_err)
`endif
    );

    always #5 clk = ~clk;

    function automatic wb_t mk_wb(input logic rw, input logic mt, input logic [31:0] alu,
                                  input logic [31:0] ld, input logic [4:0] rd);
        wb_t w;
        w.rw = rw; w.mt = mt; w.alu = alu; w.ld = ld; w.rd = rd;
        return w;
    endfunction

    function automatic wb_t obs_wb();
        return mk_wb(wb_reg_write_out, wb_memtoreg_out, wb_alu_result, wb_load_data, wb_rd_index);
    endfunction

    task automatic drive_op(input logic mr, input logic mw, input logic rw, input logic mt,
                            input logic [31:0] addr, input logic [31:0] rs2,
                            input logic [2:0] mode, input logic [4:0] rd);
        in_valid = 1'b1; mem_read = mr; mem_write = mw; wb_reg_write = rw; wb_memtoreg = mt;
        ex_result = addr; rs2_data = rs2; mem_mode = mode; rd_index = rd;
    endtask

    task automatic clear_op();
        in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; wb_reg_write = 1'b0; wb_memtoreg = 1'b0;
    endtask

    task automatic wait_wb(output bit seen, output int lat, output wb_t obs);
        seen = 1'b0; lat = 0; obs = '0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            lat++;
            if (wb_valid === 1'b1) begin
                seen = 1'b1;
                obs = obs_wb();
                break;
            end
        end
    endtask

    // Bus responder: accepts after rdy extra valid cycles; for loads answers after rsp_dly idle WAIT cycles.
    task automatic bus_serve(input int rdy, input bit is_load, input int rsp_dly, input logic [31:0] rdata,
                             output bit got, output int vcyc, output req_t obs, output bit stable,
                             output bit wait_low);
        got = 1'b0; vcyc = 0; stable = 1'b1; wait_low = 1'b1; obs = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_req_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) return;
        obs = {bus_req_we, bus_req_addr, bus_req_wdata, bus_req_wstrb};
        for (int k = 0; k <= rdy; k++) begin
            if (k > 0) @(negedge clk);
            if (bus_req_valid !== 1'b1 || {bus_req_we, bus_req_addr, bus_req_wdata, bus_req_wstrb} !== obs)
                stable = 1'b0;
            vcyc++;
            if (k == rdy) bus_req_ready = 1'b1;
        end
        @(posedge clk);
        #1 bus_req_ready = 1'b0;
        if (is_load) begin
            for (int j = 0; j <= rsp_dly; j++) begin
                @(negedge clk);
                if (bus_req_valid !== 1'b0) wait_low = 1'b0;
                if (j == rsp_dly) begin
                    bus_rsp_valid = 1'b1;
                    bus_rsp_rdata = rdata;
                end
            end
            @(posedge clk);
            #1 bus_rsp_valid = 1'b0;
            bus_rsp_rdata = $urandom;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_op();
        repeat (2) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if ({stall, bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata, bus_req_wstrb, wb_valid,
             wb_reg_write_out, wb_memtoreg_out, wb_alu_result, wb_load_data, wb_rd_index} !== '0)
            $display("FAIL reset_outputs: got nonzero (stall=%b req_valid=%b wb_valid=%b) want all 0",
                     stall, bus_req_valid, wb_valid);
        else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_alu();
        bit seen; int lat; wb_t obs; wb_t exp;
        @(posedge clk); #1;
        drive_op(1'b0, 1'b0, 1'b1, 1'b0, 32'h1234, 32'h0, 3'b010, 5'd7);
        sb.push_back(mk_wb(1'b1, 1'b0, 32'h1234, 32'h0, 5'd7));
        @(negedge clk);
        total_cnt++;
        if (stall !== 1'b0) $display("FAIL alu_stall: got %b want 0", stall); else pass_cnt++;
        @(posedge clk); #1 clear_op();
        wait_wb(seen, lat, obs);
        total_cnt++;
        if (!seen || lat != 1) $display("FAIL alu_latency: seen=%0b lat=%0d want seen=1 lat=1", seen, lat);
        else pass_cnt++;
        exp = sb.pop_front();
        total_cnt++;
        if (obs !== exp) $display("FAIL alu_wb: got %h want %h", obs, exp); else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (wb_valid !== 1'b0 || stall !== 1'b0)
            $display("FAIL alu_pulse: wb_valid=%b stall=%b want 0 0", wb_valid, stall);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        wb_t exp;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i < 3) begin
                drive_op(1'b0, 1'b0, (i != 1), 1'b0, 32'h100 + i, 32'h0, 3'b000, 5'(10 + i));
                sb.push_back(mk_wb((i != 1), 1'b0, 32'h100 + i, 32'h0, 5'(10 + i)));
            end else begin
                clear_op();
            end
            @(negedge clk);
            if (i > 0) begin
                total_cnt++;
                if (wb_valid !== 1'b1 || stall !== 1'b0)
                    $display("FAIL b2b_valid[%0d]: wb_valid=%b stall=%b want 1 0", i, wb_valid, stall);
                else pass_cnt++;
                exp = sb.pop_front();
                total_cnt++;
                if (obs_wb() !== exp) $display("FAIL b2b_wb[%0d]: got %h want %h", i, obs_wb(), exp);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_store();
        st_vec_t v[$];
        bit got, stable, wl, seen; int vcyc, lat; req_t robs, rexp; wb_t obs, exp;
        v.push_back('{32'h1003, 32'h000000A5, 3'b000, 1, 32'hA5A5A5A5, 4'b1000});
        v.push_back('{32'h1002, 32'h1234BEEF, 3'b001, 0, 32'hBEEFBEEF, 4'b1100});
        v.push_back('{32'h1000, 32'h00000077, 3'b000, 2, 32'h77777777, 4'b0001});
        v.push_back('{32'h1004, 32'hCAFEF00D, 3'b010, 0, 32'hCAFEF00D, 4'b1111});
`ifndef MEM_MISALIGN_TRAP_EN
        v.push_back('{32'h1001, 32'h0000ABCD, 3'b001, 0, 32'hABCDABCD, 4'b0011});
        v.push_back('{32'h1007, 32'h89ABCDEF, 3'b010, 1, 32'h89ABCDEF, 4'b1111});
`endif
        foreach (v[n]) begin
            @(posedge clk); #1;
            drive_op(1'b0, 1'b1, 1'b0, 1'b0, v[n].addr, v[n].rs2, v[n].mode, 5'd3);
            sb.push_back(mk_wb(1'b0, 1'b0, v[n].addr, 32'h0, 5'd3));
            @(negedge clk);
            total_cnt++;
            if (stall !== 1'b1 || bus_req_valid !== 1'b0)
                $display("FAIL st_issue[%0d]: stall=%b req_valid=%b want 1 0", n, stall, bus_req_valid);
            else pass_cnt++;
            bus_serve(v[n].rdy, 1'b0, 0, 32'h0, got, vcyc, robs, stable, wl);
            total_cnt++;
            if (!got || !stable || vcyc != v[n].rdy + 1)
                $display("FAIL st_hold[%0d]: got=%0b stable=%0b cycles=%0d want 1 1 %0d",
                         n, got, stable, vcyc, v[n].rdy + 1);
            else pass_cnt++;
            rexp = {1'b1, v[n].addr[31:2], 2'b00, v[n].wdata, v[n].wstrb};
            total_cnt++;
            if (robs !== rexp) $display("FAIL st_req[%0d]: got %h want %h", n, robs, rexp); else pass_cnt++;
            wait_wb(seen, lat, obs);
            total_cnt++;
            if (!seen || lat != 1 || stall !== 1'b0)
                $display("FAIL st_done[%0d]: seen=%0b lat=%0d stall=%b want 1 1 0", n, seen, lat, stall);
            else pass_cnt++;
            exp = sb.pop_front();
            total_cnt++;
            if (obs !== exp) $display("FAIL st_wb[%0d]: got %h want %h", n, obs, exp); else pass_cnt++;
            @(posedge clk); #1 clear_op();
            @(negedge clk);
            total_cnt++;
            if (wb_valid !== 1'b0 || bus_req_valid !== 1'b0)
                $display("FAIL st_single[%0d]: wb_valid=%b req_valid=%b want 0 0", n, wb_valid, bus_req_valid);
            else pass_cnt++;
        end
    endtask

    task automatic test_load();
        ld_vec_t v[$];
        bit got, stable, wl, seen; int vcyc, lat; req_t robs, rexp; wb_t obs, exp;
        v.push_back('{32'h2001, 3'b000, 3, 32'h00008000, 32'hFFFFFF80});
        v.push_back('{32'h2002, 3'b101, 0, 32'hBEEF1234, 32'h0000BEEF});
        v.push_back('{32'h2002, 3'b001, 1, 32'hBEEF1234, 32'hFFFFBEEF});
        v.push_back('{32'h2003, 3'b100, 0, 32'h80FF0000, 32'h00000080});
        v.push_back('{32'h2000, 3'b001, 2, 32'h12347FFF, 32'h00007FFF});
        v.push_back('{32'h2000, 3'b010, 0, 32'hDEADBEEF, 32'hDEADBEEF});
`ifndef MEM_MISALIGN_TRAP_EN
        v.push_back('{32'h3002, 3'b010, 0, 32'h11223344, 32'h11223344});
`endif
        foreach (v[n]) begin
            @(posedge clk); #1;
            // mem_write also set on the first entry: both set must behave as a load.
            drive_op(1'b1, (n == 0), 1'b1, 1'b1, v[n].addr, 32'hFFFFFFFF, v[n].mode, 5'(20 + n));
            sb.push_back(mk_wb(1'b1, 1'b1, v[n].addr, v[n].ld, 5'(20 + n)));
            bus_serve(0, 1'b1, v[n].rsp_dly, v[n].rdata, got, vcyc, robs, stable, wl);
            rexp = {1'b0, v[n].addr[31:2], 2'b00, robs.wdata, robs.wstrb};
            total_cnt++;
            if (!got || robs !== rexp) $display("FAIL ld_req[%0d]: got %h want %h", n, robs, rexp);
            else pass_cnt++;
            total_cnt++;
            if (!wl) $display("FAIL ld_wait[%0d]: req_valid high in WAIT want low", n); else pass_cnt++;
            wait_wb(seen, lat, obs);
            total_cnt++;
            if (!seen || lat != 1 || stall !== 1'b0)
                $display("FAIL ld_done[%0d]: seen=%0b lat=%0d stall=%b want 1 1 0", n, seen, lat, stall);
            else pass_cnt++;
            exp = sb.pop_front();
            total_cnt++;
            if (obs !== exp) $display("FAIL ld_wb[%0d]: got %h want %h", n, obs, exp); else pass_cnt++;
            @(posedge clk); #1 clear_op();
        end
    endtask

    task automatic test_reset_mid_access();
        bit seen, bad; int lat; wb_t obs, exp;
        @(posedge clk); #1;
        drive_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h2001, 32'h0, 3'b000, 5'd4);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus_req_valid === 1'b1) begin seen = 1'b1; break; end
        end
        bus_req_ready = 1'b1;
        @(posedge clk); #1 bus_req_ready = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (!seen || stall !== 1'b1) $display("FAIL rst_wait_entry: seen=%0b stall=%b want 1 1", seen, stall);
        else pass_cnt++;
        #2 rst_n = 1'b0;
        clear_op();
        #1;
        total_cnt++;
        if ({stall, bus_req_valid, wb_valid, wb_reg_write_out, wb_alu_result, wb_rd_index} !== '0)
            $display("FAIL rst_abort: stall=%b req_valid=%b wb_valid=%b alu=%h want all 0",
                     stall, bus_req_valid, wb_valid, wb_alu_result);
        else pass_cnt++;
        @(posedge clk); #1 rst_n = 1'b1;
        #1 bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h00008000;
        @(posedge clk); #1 bus_rsp_valid = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (wb_valid !== 1'b0 || bus_req_valid !== 1'b0 || stall !== 1'b0 || wb_load_data !== '0) bad = 1'b1;
        end
        total_cnt++;
        if (bad) $display("FAIL rst_late_rsp: activity after reset want none"); else pass_cnt++;
        @(posedge clk); #1;
        drive_op(1'b0, 1'b0, 1'b1, 1'b0, 32'h5555, 32'h0, 3'b010, 5'd1);
        sb.push_back(mk_wb(1'b1, 1'b0, 32'h5555, 32'h0, 5'd1));
        @(posedge clk); #1 clear_op();
        wait_wb(seen, lat, obs);
        exp = sb.pop_front();
        total_cnt++;
        if (!seen || lat != 1 || obs !== exp)
            $display("FAIL rst_idle: seen=%0b lat=%0d got %h want 1 1 %h", seen, lat, obs, exp);
        else pass_cnt++;
    endtask

`ifdef MEM_MISALIGN_TRAP_EN
    task automatic test_misalign();
        wb_t exp;
        @(posedge clk); #1;
        drive_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h3002, 32'h0, 3'b010, 5'd9);
        sb.push_back(mk_wb(1'b0, 1'b1, 32'h3002, 32'h0, 5'd9));
        @(negedge clk);
        total_cnt++;
        if (stall !== 1'b0) $display("FAIL mis_stall: got %b want 0", stall); else pass_cnt++;
        @(posedge clk); #1 clear_op();
        @(negedge clk);
        total_cnt++;
        if (wb_valid !== 1'b1 || misalign_err !== 1'b1 || bus_req_valid !== 1'b0)
            $display("FAIL mis_flag: wb_valid=%b err=%b req_valid=%b want 1 1 0",
                     wb_valid, misalign_err, bus_req_valid);
        else pass_cnt++;
        exp = sb.pop_front();
        total_cnt++;
        if (obs_wb() !== exp) $display("FAIL mis_wb: got %h want %h", obs_wb(), exp); else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (misalign_err !== 1'b0 || wb_valid !== 1'b0 || bus_req_valid !== 1'b0)
            $display("FAIL mis_pulse: err=%b wb_valid=%b req_valid=%b want 0 0 0",
                     misalign_err, wb_valid, bus_req_valid);
        else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_store();
        test_load();
        test_reset_mid_access();
`ifdef MEM_MISALIGN_TRAP_EN
        test_misalign();
`endif
        total_cnt++;
        if (sb.size() != 0) $display("FAIL sb_empty: %0d left want 0", sb.size()); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
